alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Pipelined decode/issue stage that produces the operand and `ALUSel` inputs consumed by the 32-bit RV32I ALU. It accepts one instruction per cycle with its register-file read data and PC, decodes OP, OP-IMM, LUI and AUIPC, and presents a registered ALU request to the execute stage. The request is held under a valid/ready handshake and can be flushed.

## Interface
- `nbit`, 32: datapath width; only 32 is supported.
- `clk`  input  1  clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `flush`  input  1  discards the held request and any request accepted this cycle.
- `in_valid`  input  1  instruction/operands valid.
- `in_ready`  output  1  stage can accept.
- `instr`  input  32  instruction word.
- `pc`  input  nbit  instruction address.
- `rs1_data`, `rs2_data`  input  nbit  register-file read data.
- `out_valid`  output  1  ALU request valid.
- `out_ready`  input  1  execute stage accepts.
- `ALUSel`  output  4  ALU function: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- `in1`, `in2`  output  nbit  ALU operands.
- `rd`  output  5  destination register.
- `reg_wen`  output  1  write-back enable.
- `illegal`  output  1  request carries an undecodable instruction.
- `illegal_cnt`  output  8  saturating count of accepted illegal instructions.

## Operation
- `in_ready = !out_valid || out_ready`. Accept = `in_valid && in_ready`.
- OP (0110011): funct7=0000000 selects by funct3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND. funct7=0100000 selects 000 SUB or 101 SRA. All other encodings are illegal. `in1=rs1_data`, `in2=rs2_data`.
- OP-IMM (0010011): funct3 000/010/011/100/110/111 select ADD/SLT/SLTU/XOR/OR/AND with a sign-extended I-immediate in `in2`.
  - 001 is SLL only with instr[31:25]=0000000.
  - 101 is SRL with 0000000 or SRA with 0100000.
  - For shifts, `in2` = zero-extended instr[24:20]. Any other funct7 is illegal.
- LUI (0110111): ADD, `in1=0`, `in2={instr[31:12],12'b0}`.
- AUIPC (0010111): ADD, `in1=pc`, `in2` = the U-immediate.
- Any other opcode is illegal.
- `rd=instr[11:7]`. `reg_wen=1` for legal requests with rd≠0; otherwise 0.
- Illegal request: `illegal=1`, `ALUSel=ADD`, `in1=in2=0`, `reg_wen=0`. It still flows through the handshake.
- `illegal_cnt` increments on each accepted illegal instruction not killed by `flush`, and saturates at 255.

## Timing
- Latency 1: an accept at edge N shows `out_valid` and the decoded fields after edge N.
- Hold: while `out_valid && !out_ready`, every output stays stable.
- Pass-through: `out_valid && out_ready && in_valid` replaces the request in the same edge, with no bubble.
- Completion: `out_valid && out_ready && !in_valid` makes `out_valid=0` next cycle.
- Flush has priority. At the next edge `out_valid=0`, any concurrently accepted input is dropped, and `illegal_cnt` is not incremented for it.
- Reset (asynchronous, may occur mid-hold): `out_valid=0`, `ALUSel=0`, `in1=in2=0`, `rd=0`, `reg_wen=0`, `illegal=0`, `illegal_cnt=0`. `in_ready=1` during and after reset.
- Data registers only load on accept. Registered fields are don't-care when `out_valid=0` after a flush but must equal 0 after reset.

## Structure
- Shared package `alu_pkg`: `alu_op_e` enum (the ten codes above), opcode localparams (OP, OP_IMM, LUI, AUIPC), and funct7 constants. The ALU is migrated to import the same enum.
- One combinational sub-module, `rv32_alu_decoder`: instr/pc/rs data in; ALUSel/in1/in2/rd/reg_wen/illegal out.
- The top level holds the output register, the handshake and the counter.

## Test plan
- SUB x3,x1,x2 (`0x402081B3`), rs1_data=10, rs2_data=3, out_ready=1 → next cycle `out_valid=1`, `ALUSel=1`, in1=10, in2=3, rd=3, reg_wen=1.
- SRAI x5,x6,4 (`0x40435293`) → `ALUSel=7`, in2=4, rd=5. ADDI x1,x0,-1 (`0xFFF00093`) → `ALUSel=0`, in2=`0xFFFFFFFF`.
- LUI x7,0x12345 (`0x123453B7`) → in1=0, in2=`0x12345000`. AUIPC x7 with same immediate (`0x12345397`), pc=`0x100` → in1=`0x100`, in2=`0x12345000`.
- Backpressure: accept A, hold out_ready=0 for 3 cycles while B is offered → in_ready=0 and A stable. out_ready=1 → A retires and B is accepted in the same edge, appearing next cycle.
- Illegal MUL (`0x02208033`) → illegal=1, reg_wen=0, `illegal_cnt` 0→1. 300 back-to-back illegal instructions → count saturates at 255. The same instruction with flush in its accept cycle → no count and no output.
- Flush while holding, then assert rst asynchronously mid-hold → `out_valid` drops (immediately for reset), all outputs 0, and in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the RV32I issue stage and the ALU.
// Contents: alu_op_e (ALUSel encoding), major opcodes, funct7 constants,
// counter limit and a funct3-to-operation helper for OP/OP-IMM.
package alu_pkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [6:0] Funct7Base = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    localparam logic [7:0] IllegalCntMax = 8'hFF;

    // Base-encoding operation for a funct3 value (funct7 = 0000000 for OP).
    function automatic alu_op_e base_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake/bus bundle between the front end, the issue stage and execute.
// master: drives instruction, operands, flush and out_ready.
// slave : the issue stage; drives in_ready and the registered ALU request.
interface alu_issue_stage_if #(
    parameter int unsigned nbit = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [nbit-1:0] pc;
    logic [nbit-1:0] rs1_data;
    logic [nbit-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      ALUSel;
    logic [nbit-1:0] in1;
    logic [nbit-1:0] in2;
    logic [4:0]      rd;
    logic            reg_wen;
    logic            illegal;
    logic [7:0]      illegal_cnt;

    modport master (
        output flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, ALUSel, in1, in2, rd, reg_wen, illegal, illegal_cnt
    );

    modport slave (
        input  flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, ALUSel, in1, in2, rd, reg_wen, illegal, illegal_cnt
    );
endinterface

// File: rtl/rv32_alu_decoder.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC.
// Inputs : instr, pc, rs1_data, rs2_data.
// Outputs: alu_sel, in1, in2, rd, reg_wen, illegal. Illegal encodings
//          produce ADD with zero operands and no write-back.
module rv32_alu_decoder
    import alu_pkg::*;
#(
    parameter int unsigned nbit = 32
) (
    input  logic [31:0]     instr,
    input  logic [nbit-1:0] pc,
    input  logic [nbit-1:0] rs1_data,
    input  logic [nbit-1:0] rs2_data,
    output alu_op_e         alu_sel,
    output logic [nbit-1:0] in1,
    output logic [nbit-1:0] in2,
    output logic [4:0]      rd,
    output logic            reg_wen,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [nbit-1:0] imm_i;
    logic [nbit-1:0] imm_u;
    logic [nbit-1:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'd0, instr[24:20]};
    assign rd     = instr[11:7];

    always_comb begin
        alu_sel = AluAdd;
        in1     = rs1_data;
        in2     = rs2_data;
        illegal = 1'b0;

        case (opcode)
            OP: begin
                if (funct7 == Funct7Base) begin
                    alu_sel = base_op(funct3);
                end else if (funct7 == Funct7Alt && funct3 == 3'b000) begin
                    alu_sel = AluSub;
                end else if (funct7 == Funct7Alt && funct3 == 3'b101) begin
                    alu_sel = AluSra;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                if (funct3 == 3'b001) begin
                    // Immediate shifts: upper bits are funct7, not immediate.
                    in2     = shamt;
                    alu_sel = AluSll;
                    illegal = (funct7 != Funct7Base);
                end else if (funct3 == 3'b101) begin
                    in2 = shamt;
                    if (funct7 == Funct7Base) begin
                        alu_sel = AluSrl;
                    end else if (funct7 == Funct7Alt) begin
                        alu_sel = AluSra;
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    in2     = imm_i;
                    alu_sel = base_op(funct3);
                end
            end
            LUI: begin
                in1 = '0;
                in2 = imm_u;
            end
            AUIPC: begin
                in1 = pc;
                in2 = imm_u;
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            alu_sel = AluAdd;
            in1     = '0;
            in2     = '0;
        end
    end

    assign reg_wen = !illegal && (rd != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the RV32I ALU. Accepts one instruction per
// cycle, decodes it and holds a registered ALU request under valid/ready.
// Ports: clk, rst (async, active-high) and bus (alu_issue_stage_if.slave)
// carrying flush, the input handshake/operands, the output request and
// the saturating illegal-instruction counter.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned nbit = 32
) (
    input logic              clk,
    input logic              rst,
    alu_issue_stage_if.slave bus
);

    alu_op_e         dec_sel;
    logic [nbit-1:0] dec_in1;
    logic [nbit-1:0] dec_in2;
    logic [4:0]      dec_rd;
    logic            dec_wen;
    logic            dec_illegal;

    rv32_alu_decoder #(
        .nbit(nbit)
    ) u_decoder (
        .instr   (bus.instr),
        .pc      (bus.pc),
        .rs1_data(bus.rs1_data),
        .rs2_data(bus.rs2_data),
        .alu_sel (dec_sel),
        .in1     (dec_in1),
        .in2     (dec_in2),
        .rd      (dec_rd),
        .reg_wen (dec_wen),
        .illegal (dec_illegal)
    );

    logic            valid_q;
    alu_op_e         sel_q;
    logic [nbit-1:0] in1_q;
    logic [nbit-1:0] in2_q;
    logic [4:0]      rd_q;
    logic            wen_q;
    logic            illegal_q;
    logic [7:0]      cnt_q;

    logic accept;
    logic load;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    // A flush kills anything accepted in the same cycle.
    assign load         = accept && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            sel_q     <= AluAdd;
            in1_q     <= '0;
            in2_q     <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end

            if (load) begin
                sel_q     <= dec_sel;
                in1_q     <= dec_in1;
                in2_q     <= dec_in2;
                rd_q      <= dec_rd;
                wen_q     <= dec_wen;
                illegal_q <= dec_illegal;
            end

            if (load && dec_illegal && cnt_q != IllegalCntMax) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.ALUSel      = sel_q;
    assign bus.in1         = in1_q;
    assign bus.in2         = in2_q;
    assign bus.rd          = rd_q;
    assign bus.reg_wen     = wen_q;
    assign bus.illegal     = illegal_q;
    assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, handshake
// sequences, randomized traffic against a transaction-level model.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.nbit(32)) bus ();

    alu_issue_stage #(.nbit(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } req_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        req_t        exp;
    } vec_t;

    localparam logic [31:0] InsMul  = 32'h02208033;
    localparam logic [31:0] InsSub  = 32'h402081B3;
    localparam logic [31:0] InsAddi = 32'hFFF00093;

    int checks = 0;
    int errors = 0;

    // Model state: the request the stage should be presenting, and the count.
    logic pend_v;
    req_t pend;
    int   cnt_m;

    // Reference decode straight from the ISA rules.
    function automatic req_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                        input logic [31:0] a, input logic [31:0] b);
        req_t r;
        int   base_sel[8];
        logic ok;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        base_sel = '{0, 2, 3, 4, 5, 6, 8, 9};
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        ok = 1'b1;
        r.sel = 4'd0;
        r.in1 = a;
        r.in2 = b;
        if (op == 7'h33) begin
            if (f7 == 7'h00) r.sel = 4'(base_sel[f3]);
            else if (f7 == 7'h20 && f3 == 3'd0) r.sel = 4'd1;
            else if (f7 == 7'h20 && f3 == 3'd5) r.sel = 4'd7;
            else ok = 1'b0;
        end else if (op == 7'h13) begin
            if (f3 == 3'd1) begin
                r.sel = 4'd2;
                r.in2 = {27'd0, ins[24:20]};
                ok = (f7 == 7'h00);
            end else if (f3 == 3'd5) begin
                r.in2 = {27'd0, ins[24:20]};
                if (f7 == 7'h00) r.sel = 4'd6;
                else if (f7 == 7'h20) r.sel = 4'd7;
                else ok = 1'b0;
            end else begin
                r.sel = 4'(base_sel[f3]);
                r.in2 = {{20{ins[31]}}, ins[31:20]};
            end
        end else if (op == 7'h37) begin
            r.in1 = 32'd0;
            r.in2 = {ins[31:12], 12'd0};
        end else if (op == 7'h17) begin
            r.in1 = pcv;
            r.in2 = {ins[31:12], 12'd0};
        end else begin
            ok = 1'b0;
        end
        r.rd  = ins[11:7];
        r.ill = !ok;
        r.wen = ok && (r.rd != 5'd0);
        if (!ok) begin
            r.sel = 4'd0;
            r.in1 = 32'd0;
            r.in2 = 32'd0;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    task automatic apply(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.pc        = pcv;
        bus.rs1_data  = a;
        bus.rs2_data  = b;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        logic        acc;
        logic        fl;
        logic        rdy;
        logic [31:0] ins, pcv, a, b;
        acc = bus.in_valid && (!pend_v || bus.out_ready);
        fl  = bus.flush;
        rdy = bus.out_ready;
        ins = bus.instr;
        pcv = bus.pc;
        a   = bus.rs1_data;
        b   = bus.rs2_data;
        @(posedge clk);
        if (fl) begin
            pend_v = 1'b0;
        end else if (acc) begin
            pend   = ref_decode(ins, pcv, a, b);
            pend_v = 1'b1;
            if (pend.ill && cnt_m < 255) cnt_m++;
        end else if (rdy) begin
            pend_v = 1'b0;
        end
        #1;
    endtask

    task automatic check_req(input string tag, input req_t e);
        chk({tag, "/out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "/ALUSel"}, {28'd0, bus.ALUSel}, {28'd0, e.sel});
        chk({tag, "/in1"}, bus.in1, e.in1);
        chk({tag, "/in2"}, bus.in2, e.in2);
        chk({tag, "/rd"}, {27'd0, bus.rd}, {27'd0, e.rd});
        chk({tag, "/reg_wen"}, {31'd0, bus.reg_wen}, {31'd0, e.wen});
        chk({tag, "/illegal"}, {31'd0, bus.illegal}, {31'd0, e.ill});
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/in_ready"}, {31'd0, bus.in_ready}, {31'd0, !pend_v || bus.out_ready});
        chk({tag, "/out_valid"}, {31'd0, bus.out_valid}, {31'd0, pend_v});
        chk({tag, "/illegal_cnt"}, {24'd0, bus.illegal_cnt}, 32'(cnt_m));
        if (pend_v) check_req(tag, pend);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "/ALUSel"}, {28'd0, bus.ALUSel}, 32'd0);
        chk({tag, "/in1"}, bus.in1, 32'd0);
        chk({tag, "/in2"}, bus.in2, 32'd0);
        chk({tag, "/rd"}, {27'd0, bus.rd}, 32'd0);
        chk({tag, "/reg_wen"}, {31'd0, bus.reg_wen}, 32'd0);
        chk({tag, "/illegal"}, {31'd0, bus.illegal}, 32'd0);
        chk({tag, "/illegal_cnt"}, {24'd0, bus.illegal_cnt}, 32'd0);
        chk({tag, "/in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0:       w[6:0] = 7'h33;
            1, 2:    w[6:0] = 7'h13;
            3:       w[6:0] = 7'h37;
            4:       w[6:0] = 7'h17;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{"sub",   InsSub,        32'h0,   32'd10,        32'd3,  '{4'd1, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0}};
        vecs[1]  = '{"srai",  32'h40435293,  32'h0,   32'h80000000,  32'd77, '{4'd7, 32'h80000000, 32'd4, 5'd5, 1'b1, 1'b0}};
        vecs[2]  = '{"addi",  InsAddi,       32'h0,   32'd123,       32'd5,  '{4'd0, 32'd123, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0}};
        vecs[3]  = '{"lui",   32'h123453B7,  32'h40,  32'd55,        32'd66, '{4'd0, 32'd0, 32'h12345000, 5'd7, 1'b1, 1'b0}};
        vecs[4]  = '{"auipc", 32'h12345397,  32'h100, 32'd55,        32'd66, '{4'd0, 32'h100, 32'h12345000, 5'd7, 1'b1, 1'b0}};
        vecs[5]  = '{"mul",   InsMul,        32'h0,   32'd7,         32'd9,  '{4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1}};
        vecs[6]  = '{"add_x0", 32'h00208033, 32'h0,   32'd4,         32'd5,  '{4'd0, 32'd4, 32'd5, 5'd0, 1'b0, 1'b0}};
        vecs[7]  = '{"sltu",  32'h0020B233,  32'h0,   32'd1,         32'd2,  '{4'd4, 32'd1, 32'd2, 5'd4, 1'b1, 1'b0}};
        vecs[8]  = '{"and",   32'h0020FFB3,  32'h0,   32'hF0F0,      32'hFF, '{4'd9, 32'hF0F0, 32'hFF, 5'd31, 1'b1, 1'b0}};
        vecs[9]  = '{"slli_bad", 32'h40311093, 32'h0, 32'd8,         32'd8,  '{4'd0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1}};
        vecs[10] = '{"slli",  32'h00311093,  32'h0,   32'd8,         32'd9,  '{4'd2, 32'd8, 32'd3, 5'd1, 1'b1, 1'b0}};
        vecs[11] = '{"load",  32'h00002083,  32'h0,   32'd1,         32'd2,  '{4'd0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1}};
        vecs[12] = '{"xori",  32'hFFE1C113,  32'h0,   32'd6,         32'd2,  '{4'd5, 32'd6, 32'hFFFFFFFE, 5'd2, 1'b1, 1'b0}};
        vecs[13] = '{"op_alt_bad", 32'h40209033, 32'h0, 32'd6,       32'd2,  '{4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1}};

        rst    = 1'b1;
        pend_v = 1'b0;
        cnt_m  = 0;
        apply(0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0);
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First illegal instruction bumps the counter 0 -> 1.
        apply(1, InsMul, 32'd0, 32'd7, 32'd9, 1, 0);
        tick();
        apply(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        #1;
        check_req("mul_first", vecs[5].exp);
        chk("mul_first/illegal_cnt", {24'd0, bus.illegal_cnt}, 32'd1);
        tick();

        // Back-to-back vectors: each one passes through the previous.
        foreach (vecs[i]) begin
            apply(1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, 1, 0);
            tick();
            check_req(vecs[i].name, vecs[i].exp);
        end
        apply(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        tick();
        chk("drain/out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("table/illegal_cnt", {24'd0, bus.illegal_cnt}, 32'd5);

        // Backpressure: A held for three cycles while B waits.
        apply(1, InsSub, 32'd0, 32'd10, 32'd3, 1, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            apply(1, InsAddi, 32'd0, 32'd123, 32'd5, 0, 0);
            #1;
            chk("bp/in_ready", {31'd0, bus.in_ready}, 32'd0);
            check_req("bp_hold", vecs[0].exp);
            tick();
        end
        check_req("bp_hold_last", vecs[0].exp);
        apply(1, InsAddi, 32'd0, 32'd123, 32'd5, 1, 0);
        #1;
        chk("bp_release/in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        apply(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        #1;
        check_req("bp_b", vecs[2].exp);
        tick();
        chk("bp_done/out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Illegal instruction flushed in its accept cycle: no output, no count.
        apply(1, InsMul, 32'd0, 32'd7, 32'd9, 1, 1);
        tick();
        apply(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        #1;
        chk("flush_ill/out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_ill/illegal_cnt", {24'd0, bus.illegal_cnt}, 32'd5);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            apply($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            #1;
            check_model("rnd");
            tick();
        end
        apply(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        tick();
        check_model("rnd_drain");

        // Saturation: 300 back-to-back illegal instructions.
        for (int c = 0; c < 300; c++) begin
            apply(1, InsMul, 32'd0, 32'd1, 32'd2, 1, 0);
            tick();
        end
        chk("sat/illegal_cnt", {24'd0, bus.illegal_cnt}, 32'd255);
        check_model("sat");

        // Flush while holding.
        apply(1, InsSub, 32'd0, 32'd10, 32'd3, 1, 0);
        tick();
        apply(0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0);
        tick();
        check_req("flush_hold", vecs[0].exp);
        apply(0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1);
        #1;
        chk("flush_hold/in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        apply(0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0);
        #1;
        chk("flushed/out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flushed/in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Asynchronous reset in the middle of a hold.
        apply(1, InsSub, 32'd0, 32'd10, 32'd3, 1, 0);
        tick();
        apply(0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0);
        tick();
        check_req("pre_rst_hold", vecs[0].exp);
        #2;
        rst = 1'b1;
        #1;
        pend_v = 1'b0;
        cnt_m  = 0;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
